// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the nibble parity frame checker.
// A frame is four data nibbles followed by one column-parity check nibble.
package parity_frame_pkg;

    localparam int FRAME_DATA_WORDS = 4;
    localparam int NIBBLE_W         = 4;
    localparam int IDX_W            = $clog2(FRAME_DATA_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef logic [NIBBLE_W-1:0] nibble_t;
    typedef logic [IDX_W-1:0]    idx_t;

    // True when the slot being written is the final data nibble of the frame.
    function automatic logic is_last_data(input idx_t idx);
        return idx == idx_t'(FRAME_DATA_WORDS - 1);
    endfunction

endpackage

// File: rtl/col_parity_acc.sv
// Running column-parity accumulator: load restarts it with the first nibble,
// en folds each further nibble in with XOR.
module col_parity_acc
    import parity_frame_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                en,
    input  logic [NIBBLE_W-1:0] d,
    output logic [NIBBLE_W-1:0] acc
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= d;
        end else if (en) begin
            acc <= acc ^ d;
        end
    end

endmodule

// File: rtl/parity_frame_checker.sv
// Receives framed nibbles, checks the trailing column-parity nibble and holds
// the frame result until the downstream accepts it; counts bad frames.
module parity_frame_checker
    import parity_frame_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NIBBLE_W-1:0]  in_data,
    input  logic                 in_sof,
    output logic [NIBBLE_W-1:0]  out0,
    output logic [NIBBLE_W-1:0]  out1,
    output logic [NIBBLE_W-1:0]  out2,
    output logic [NIBBLE_W-1:0]  out3,
    output logic [NIBBLE_W-1:0]  syndrome,
    output logic                 err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sync_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_t  state, next_state;
    idx_t    idx, idx_next;
    nibble_t acc;
    nibble_t syndrome_next;
    nibble_t slot [FRAME_DATA_WORDS];

    logic xfer;
    logic acc_load, acc_en;
    logic slot_we;
    idx_t slot_idx;
    logic check_xfer;
    logic sync_pulse;

    assign in_ready      = (state != HOLD);
    assign out_valid     = (state == HOLD);
    assign xfer          = in_valid && in_ready;
    assign syndrome_next = acc ^ in_data;

    col_parity_acc u_acc (
        .clk  (clk),
        .rst  (rst),
        .load (acc_load),
        .en   (acc_en),
        .d    (in_data),
        .acc  (acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= idx_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        idx_next   = idx;
        acc_load   = 1'b0;
        acc_en     = 1'b0;
        slot_we    = 1'b0;
        slot_idx   = idx;
        check_xfer = 1'b0;
        sync_pulse = 1'b0;

        unique case (state)
            IDLE: begin
                // Words without a start-of-frame marker are consumed and dropped.
                if (xfer && in_sof) begin
                    acc_load   = 1'b1;
                    slot_we    = 1'b1;
                    slot_idx   = '0;
                    idx_next   = idx_t'(1);
                    next_state = DATA;
                end
            end
            DATA, CHECK: begin
                if (xfer) begin
                    if (in_sof) begin
                        // A new frame starts mid-frame: drop the partial one.
                        sync_pulse = 1'b1;
                        acc_load   = 1'b1;
                        slot_we    = 1'b1;
                        slot_idx   = '0;
                        idx_next   = idx_t'(1);
                        next_state = DATA;
                    end else if (state == DATA) begin
                        acc_en   = 1'b1;
                        slot_we  = 1'b1;
                        idx_next = idx + idx_t'(1);
                        if (is_last_data(idx)) begin
                            next_state = CHECK;
                        end
                    end else begin
                        check_xfer = 1'b1;
                        idx_next   = '0;
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the staging slots are plain storage and are never read before a
    // start-of-frame rewrites slot 0, so they carry no reset.
    always_ff @(posedge clk) begin
        if (slot_we) begin
            slot[slot_idx] <= in_data;
        end
    end

    // Published results change only on a check-word transfer and otherwise
    // keep the previous frame's values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out0     <= '0;
            out1     <= '0;
            out2     <= '0;
            out3     <= '0;
            syndrome <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= sync_pulse;
            if (check_xfer) begin
                out0     <= slot[0];
                out1     <= slot[1];
                out2     <= slot[2];
                out3     <= slot[3];
                syndrome <= syndrome_next;
                err      <= |syndrome_next;
                if ((|syndrome_next) && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: good/bad frames, backpressure,
// resynchronisation, idle discard, reset mid-frame and counter saturation.
module tb_parity_frame_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_s = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       out_ready = 1'b0;

    logic       in_ready, err, out_valid, sync_err;
    logic [3:0] out0, out1, out2, out3, syndrome;
    logic [7:0] err_cnt;

    logic       in_ready_s, err_s, out_valid_s, sync_err_s;
    logic [3:0] out0_s, out1_s, out2_s, out3_s, syndrome_s;
    logic [1:0] err_cnt_s;

    int checks = 0;
    int fails = 0;
    int sync_total = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sync_err === 1'b1) sync_total++;
    end

    parity_frame_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .syndrome(syndrome), .err(err), .out_valid(out_valid),
        .out_ready(out_ready), .sync_err(sync_err), .err_cnt(err_cnt)
    );

    parity_frame_checker #(.ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst_s), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_sof(in_sof),
        .out0(out0_s), .out1(out1_s), .out2(out2_s), .out3(out3_s),
        .syndrome(syndrome_s), .err(err_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .sync_err(sync_err_s), .err_cnt(err_cnt_s)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one word at a negedge; it transfers on the following posedge.
    task automatic send(input logic [3:0] d, input logic sof);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w == 20) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic frame(input logic [3:0] d0, d1, d2, d3, c);
        send(d0, 1'b1);
        send(d1, 1'b0);
        send(d2, 1'b0);
        send(d3, 1'b0);
        send(c,  1'b0);
    endtask

    task automatic drain();
        int w;
        @(negedge clk);
        out_ready = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (out_valid !== 1'b0 && w < 10);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_timeout: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out0, out1, out2, out3} !== 16'h0000) begin
            fails++; $display("FAIL reset_outs: got %h, required 0000", {out0, out1, out2, out3});
        end
        checks++;
        if ({syndrome, err, out_valid, sync_err} !== 7'b0) begin
            fails++; $display("FAIL reset_flags: got %b, required 0000000", {syndrome, err, out_valid, sync_err});
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            fails++; $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_good_frame();
        int s0 = sync_total;
        send(4'h3, 1'b1);
        send(4'h5, 1'b0);
        send(4'h9, 1'b0);
        send(4'hC, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL good_early_valid: got %b, required 0", out_valid);
        end
        send(4'h3, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL good_valid_latency: got %b, required 1", out_valid);
        end
        @(negedge clk);
        checks++;
        if ({out0, out1, out2, out3} !== 16'h359C) begin
            fails++; $display("FAIL good_outs: got %h, required 359c", {out0, out1, out2, out3});
        end
        checks++;
        if (syndrome !== 4'h0 || err !== 1'b0) begin
            fails++; $display("FAIL good_syndrome: got syn=%h err=%b, required syn=0 err=0", syndrome, err);
        end
        checks++;
        if (err_cnt !== 8'(exp_cnt) || in_ready !== 1'b0 || sync_total != s0) begin
            fails++; $display("FAIL good_side: err_cnt=%0d in_ready=%b syncs=%0d, required %0d 0 0",
                              err_cnt, in_ready, sync_total - s0, exp_cnt);
        end
        drain();
        checks++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL good_back_to_idle: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_bad_check();
        frame(4'h3, 4'h5, 4'h9, 4'hC, 4'h7);
        exp_cnt++;
        @(negedge clk);
        checks++;
        if (syndrome !== 4'b0100 || err !== 1'b1) begin
            fails++; $display("FAIL bad_syndrome: got syn=%h err=%b, required syn=4 err=1", syndrome, err);
        end
        checks++;
        if (err_cnt !== 8'(exp_cnt)) begin
            fails++; $display("FAIL bad_err_cnt: got %0d, required %0d", err_cnt, exp_cnt);
        end
        drain();
    endtask

    task automatic test_backpressure();
        frame(4'h1, 4'h2, 4'h4, 4'h8, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out0, out1, out2, out3} !== 16'h1248 ||
                syndrome !== 4'h0 || err !== 1'b0) begin
                fails++; $display("FAIL bp_hold_%0d: rdy=%b vld=%b outs=%h syn=%h err=%b, required 0 1 1248 0 0",
                                  i, in_ready, out_valid, {out0, out1, out2, out3}, syndrome, err);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_release: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_resync();
        int s0 = sync_total;
        send(4'hA, 1'b1);
        send(4'h1, 1'b0);
        frame(4'h2, 4'h2, 4'h2, 4'h2, 4'h0);
        @(negedge clk);
        checks++;
        if (sync_total - s0 != 1) begin
            fails++; $display("FAIL resync_pulses: got %0d, required 1", sync_total - s0);
        end
        checks++;
        if ({out0, out1, out2, out3} !== 16'h2222 || err !== 1'b0 || syndrome !== 4'h0) begin
            fails++; $display("FAIL resync_result: outs=%h syn=%h err=%b, required 2222 0 0",
                              {out0, out1, out2, out3}, syndrome, err);
        end
        drain();
    endtask

    task automatic test_idle_discard_and_gaps();
        send(4'h7, 1'b0);
        send(4'hE, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {out0, out1, out2, out3} !== 16'h2222) begin
            fails++; $display("FAIL idle_discard: vld=%b rdy=%b outs=%h, required 0 1 2222",
                              out_valid, in_ready, {out0, out1, out2, out3});
        end
        send(4'h6, 1'b1);
        repeat (3) @(negedge clk);
        send(4'h3, 1'b0);
        repeat (2) @(negedge clk);
        send(4'h5, 1'b0);
        send(4'hF, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL gaps_early_valid: got %b, required 0", out_valid);
        end
        send(4'hE, 1'b0);
        exp_cnt++;
        @(negedge clk);
        checks++;
        if ({out0, out1, out2, out3} !== 16'h635F || syndrome !== 4'h1 || err !== 1'b1 ||
            err_cnt !== 8'(exp_cnt)) begin
            fails++; $display("FAIL gaps_result: outs=%h syn=%h err=%b cnt=%0d, required 635f 1 1 %0d",
                              {out0, out1, out2, out3}, syndrome, err, err_cnt, exp_cnt);
        end
        drain();
    endtask

    task automatic test_abort_in_check();
        int s0 = sync_total;
        send(4'h1, 1'b1);
        send(4'h1, 1'b0);
        send(4'h1, 1'b0);
        send(4'h1, 1'b0);
        send(4'h6, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL abort_taken_as_check: out_valid=%b, required 0", out_valid);
        end
        send(4'h0, 1'b0);
        send(4'h0, 1'b0);
        send(4'h0, 1'b0);
        send(4'h6, 1'b0);
        @(negedge clk);
        checks++;
        if ({out0, out1, out2, out3} !== 16'h6000 || syndrome !== 4'h0 || err !== 1'b0 ||
            sync_total - s0 != 1 || err_cnt !== 8'(exp_cnt)) begin
            fails++; $display("FAIL abort_result: outs=%h syn=%h err=%b syncs=%0d cnt=%0d, required 6000 0 0 1 %0d",
                              {out0, out1, out2, out3}, syndrome, err, sync_total - s0, err_cnt, exp_cnt);
        end
        drain();
    endtask

    task automatic test_reset_mid_frame();
        int s0 = sync_total;
        send(4'h3, 1'b1);
        send(4'h5, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({out0, out1, out2, out3, syndrome} !== 20'h0 || {err, out_valid, sync_err} !== 3'b0 ||
            err_cnt !== 8'd0) begin
            fails++; $display("FAIL rst_mid_outputs: outs=%h syn=%h flags=%b cnt=%0d, required all 0",
                              {out0, out1, out2, out3}, syndrome, {err, out_valid, sync_err}, err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        frame(4'h3, 4'h5, 4'h9, 4'hC, 4'h3);
        @(negedge clk);
        checks++;
        if ({out0, out1, out2, out3} !== 16'h359C || syndrome !== 4'h0 || err !== 1'b0 ||
            err_cnt !== 8'd0 || sync_total != s0) begin
            fails++; $display("FAIL rst_mid_next_frame: outs=%h syn=%h err=%b cnt=%0d syncs=%0d, required 359c 0 0 0 0",
                              {out0, out1, out2, out3}, syndrome, err, err_cnt, sync_total - s0);
        end
        drain();
    endtask

    task automatic test_saturation();
        int exp_s;
        @(negedge clk);
        rst_s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            frame(4'h3, 4'h5, 4'h9, 4'hC, 4'h7);
            exp_cnt++;
            exp_s = (i + 1 > 3) ? 3 : i + 1;
            @(negedge clk);
            checks++;
            if (err_cnt_s !== 2'(exp_s) || err_s !== 1'b1) begin
                fails++; $display("FAIL sat_frame_%0d: cnt=%0d err=%b, required %0d 1", i, err_cnt_s, err_s, exp_s);
            end
            drain();
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt_s !== 2'd3) begin
            fails++; $display("FAIL sat_hold: got %0d, required 3", err_cnt_s);
        end
        checks++;
        if (err_cnt !== 8'(exp_cnt)) begin
            fails++; $display("FAIL wide_cnt: got %0d, required %0d", err_cnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_check();
        test_backpressure();
        test_resync();
        test_idle_discard_and_gaps();
        test_abort_in_check();
        test_reset_mid_frame();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 The block SHALL have parameter ERR_CNT_W, default 8, which sets the width of the saturating error counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data/in_sof are valid this cycle.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 The block SHALL have port in_data, input, 4 bits: the received nibble.
REQ-007 The block SHALL have port in_sof, input, 1 bit: marks the first data nibble of a frame.
REQ-008 The block SHALL have ports out0..out3, output, 4 bits each: the captured data nibbles in arrival order.
REQ-009 The block SHALL have port syndrome, output, 4 bits: recomputed column parity XOR the received check nibble.
REQ-010 The block SHALL have port err, output, 1 bit: syndrome is nonzero.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a frame result is presented.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream accepts the frame result.
REQ-013 The block SHALL have port sync_err, output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-014 The block SHALL have port err_cnt, output, ERR_CNT_W bits: count of frames with err=1, saturating.

Function
REQ-015 A frame SHALL consist of 4 data nibbles D0..D3 followed by 1 check nibble C, where C[k] is the XOR of D0[k]..D3[k].
REQ-016 A word SHALL transfer when in_valid and in_ready are both high at a rising clk.
REQ-017 The FSM SHALL have states IDLE, DATA, CHECK and HOLD.
REQ-018 In IDLE, in_ready SHALL be 1; a transfer with in_sof=1 SHALL capture D0, load the accumulator with D0, and go to DATA with idx=1.
REQ-019 In IDLE, a transfer with in_sof=0 SHALL be consumed and discarded, with no other effect.
REQ-020 In DATA, each transfer SHALL store the nibble at slot idx, XOR it into the accumulator, and increment idx; the transfer at idx=3 SHALL go to CHECK.
REQ-021 In CHECK, a transfer SHALL set syndrome to the accumulator XOR in_data and set err to the reduction-OR of the syndrome.
REQ-022 The CHECK transfer SHALL also go to HOLD, with out_valid=1 from the next cycle, so check word accepted at cycle N gives the result at N+1.
REQ-023 In HOLD, in_ready SHALL be 0; out0..out3, syndrome and err SHALL stay stable until out_valid and out_ready are both high, after which out_valid drops and the state returns to IDLE on the next cycle.
REQ-024 On entry to HOLD with err=1, err_cnt SHALL increment by 1, saturating at all-ones with no wrap.
REQ-025 A transfer with in_sof=1 while in DATA or CHECK SHALL discard the partial frame and pulse sync_err for 1 cycle.
REQ-026 That same in_sof=1 word SHALL be treated as the D0 of a new frame: idx=1, state DATA.
REQ-027 A transfer with in_sof=1 in the CHECK slot SHALL be handled as an abort per REQ-025/026, not as a check word.
REQ-028 When in_valid=0, the state and the accumulator SHALL hold.
REQ-029 out0..out3, syndrome and err SHALL retain the last frame's values outside HOLD.
REQ-030 The outputs out0..out3, syndrome, err and err_cnt SHALL be driven from registers.

Reset
REQ-031 rst=1 SHALL asynchronously force state=IDLE, idx=0, accumulator=0, out0..out3=0, syndrome=0, err=0, out_valid=0, sync_err=0 and err_cnt=0.
REQ-032 in_ready SHALL be 1 after rst deasserts, since the state is IDLE.
REQ-033 Reset asserted mid-frame or in HOLD SHALL drop the frame with no sync_err pulse and no err_cnt change.

Structure
REQ-034 Shared package parity_frame_pkg SHALL hold the state typedef, FRAME_DATA_WORDS=4 and NIBBLE_W=4.
REQ-035 The running XOR SHALL be a sub-module col_parity_acc with ports clk, rst, load, en, d[3:0] and acc[3:0].
REQ-036 The FSM, data slots and err_cnt SHALL live in parity_frame_checker.

Verification
REQ-037 Good frame: sof+3, 5, 9, C, check 3 -> out0..3=3,5,9,C; syndrome=0; err=0; err_cnt unchanged; out_valid 1 cycle after the check word.
REQ-038 Bad check: same data, check 7 -> syndrome=4'b0100; err=1; err_cnt +1.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> outputs stable and in_ready=0 throughout; release -> IDLE the next cycle.
REQ-040 Resync: sof+A, 1, then sof+2, 2, 2, 2, check 0 -> sync_err pulses once; result out0..3=2,2,2,2, err=0.
REQ-041 Saturation: with ERR_CNT_W=2, send 5 bad frames -> err_cnt=3 and stays 3.
REQ-042 Reset mid-frame: assert rst after D1 -> all outputs 0 immediately; a following clean frame is checked correctly.
